ram_access_ctrl: RTL
====================

Name: ram_access_ctrl

Overview:
- Memory-side controller between the multi-cycle CPU's load/store datapath and the 4096x32 data RAM block.
- The RAM has one port and a registered read. Reads update douta only when wea=0. There is no byte-enable.
- This block converts CPU byte addresses and byte/half/word accesses into RAM word accesses.
- Sub-word stores are done as read-modify-write. Load results are byte-lane extracted and extended. Misaligned accesses are flagged.

Parameters:
- ADDR_W, 12, RAM word-address width (RAM depth = 2**ADDR_W words).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  CPU access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  CPU byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  load result, extended; registered.
- ready  out  1  one-cycle completion pulse.
- addr_err  out  1  misalignment flag; valid only while ready=1.
- ram_wea  out  1  to RAM wea.
- ram_addra  out  ADDR_W  to RAM addra; equals addr[ADDR_W+1:2].
- ram_dina  out  32  to RAM dina.
- ram_douta  in  32  from RAM douta.

Behaviour:
- Clock and reset: clock is clk; reset is rst, synchronous and active-high.
- Reset values: state IDLE, rdata 0, ready 0, addr_err 0.
- ram_wea is forced to 0 whenever rst=1, regardless of state.
- Byte order is big-endian: offset 0 maps to bits [31:24], offset 3 to [7:0]; half offset 0 maps to [31:16].
- Address bits above ADDR_W+1 are ignored, so addresses alias modulo 16 KiB.
- Alignment rules: a half access is misaligned when addr[0]=1. A word access is misaligned when addr[1:0]!=0.
- States and transitions:
  - IDLE:
    - Without req: ram_wea=0, ram_addra follows addr, ready=0.
    - On req, addr/we/size/sign_ext/wdata are latched into *_q registers.
    - Misaligned access: no RAM access; go to DONE with addr_err_q=1.
    - Load: ram_wea=0 (RAM read issued); go to RD_WAIT.
    - Word store: ram_wea=1 and ram_dina=wdata this cycle; go to DONE.
    - Byte/half store: ram_wea=0 (read issued); go to RMW_WAIT.
  - RD_WAIT:
    - ram_douta is valid.
    - rdata is loaded with the selected lane, extended per sign_ext_q.
    - Go to DONE.
  - RMW_WAIT:
    - ram_wea=1 and ram_addra=addr_q word.
    - ram_dina = ram_douta with the target lane replaced by wdata_q[7:0] or wdata_q[15:0].
    - Go to DONE.
  - DONE:
    - ready=1 for exactly one cycle; addr_err=addr_err_q.
    - Return to IDLE.
    - A req seen in this cycle is ignored. The requester re-presents it in IDLE.
- Latency (cycles after the IDLE cycle in which req was sampled):
  - Misaligned access: ready in cycle 1.
  - Word store: ready in cycle 1.
  - Load: ready in cycle 2.
  - Byte/half store: ready in cycle 2.
- Handshake: the requester holds req until ready. req asserted while the block is not in IDLE has no effect.
- rdata changes only on completion of an aligned load. It holds its value across stores and errors.
- Misaligned store: the RAM is never written.
- Reset mid-operation: the transaction is abandoned and no ready pulse is produced. RAM contents are unchanged, including a pending RMW write.

Decomposition:
- Shared include/package mem_ctrl_defs holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encodings S_IDLE, S_RD_WAIT, S_RMW_WAIT, S_DONE.
- Sub-module mem_lane_align (combinational) provides:
  - load extract and extend: word, offset, size, sign_ext -> 32-bit result;
  - store merge: old word, wdata, offset, size -> new word.
- The FSM stays in ram_access_ctrl.

Test Plan:
- Setup: preload RAM word 1 = 0x8899AABB.
- lw, addr 0x4: ready in cycle 2; rdata = 0x8899AABB; ram_wea stays 0 throughout.
- lb, addr 0x5, sign_ext=1: rdata = 0xFFFFFF99. lbu, addr 0x5: rdata = 0x00000099. lh, addr 0x6, sign_ext=1: rdata = 0xFFFFAABB.
- sb, addr 0x7, wdata 0x12345678:
  - one read (cycle 0), then one write (cycle 1) at ram_addra=1 with ram_dina = 0x8899AA78;
  - ready in cycle 2.
  - Follow with sh, addr 0x4, wdata 0x0000CAFE: RAM word 1 = 0xCAFEAA78.
- sw, addr 0x3FFC, wdata 0xDEADBEEF: ram_wea=1 in cycle 0 with ram_addra=0xFFF; ready in cycle 1. Then sw to addr 0x4000: ram_addra=0x000 (alias).
- lw, addr 0x6, with rdata previously 0x8899AABB: ready=1 and addr_err=1 in cycle 1; no RAM write; rdata unchanged. sh, addr 0x3: same response, and the RAM word is unchanged.
- sb, addr 0x4, with rst=1 in the RMW_WAIT cycle: ram_wea stays 0; word 1 unchanged; no ready pulse; next req is accepted in IDLE with normal latency.

Source files
------------

// File: rtl/mem_ctrl_defs.sv
// Shared encodings for the RAM access controller and its lane aligner.
package mem_ctrl_defs;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_RD_WAIT  = 2'b01,
    S_RMW_WAIT = 2'b10,
    S_DONE     = 2'b11
  } state_t;

  // Size 2'b11 behaves as a word access, so anything that is not byte or half
  // gets the word alignment rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane handling: load extract/extend and sub-word store merge.
module mem_lane_align
  import mem_ctrl_defs::*;
(
  input  logic [31:0] ld_word,
  input  logic [31:0] st_old,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load path: pick the addressed lane (offset 0 is the most significant) and extend it.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = 16'h0000;
    ld_data = ld_word;
    case (offset)
      2'd0:    ld_byte = ld_word[31:24];
      2'd1:    ld_byte = ld_word[23:16];
      2'd2:    ld_byte = ld_word[15:8];
      default: ld_byte = ld_word[7:0];
    endcase
    ld_half = offset[1] ? ld_word[15:0] : ld_word[31:16];
    case (size)
      SZ_BYTE: ld_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{sign_ext & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  // Store path: overwrite only the addressed lane of the word read back from RAM.
  always_comb begin
    st_word = st_old;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0:    st_word[31:24] = wdata[7:0];
          2'd1:    st_word[23:16] = wdata[7:0];
          2'd2:    st_word[15:8]  = wdata[7:0];
          default: st_word[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) st_word[15:0]  = wdata[15:0];
        else           st_word[31:16] = wdata[15:0];
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// CPU load/store to single-port RAM word access controller.
//   state      | meaning
//   S_IDLE     | accept req; issue read, word write, or flag misalignment
//   S_RD_WAIT  | RAM read data valid; capture extended load result
//   S_RMW_WAIT | RAM read data valid; write merged word back
//   S_DONE     | one-cycle ready pulse, addr_err valid
module ram_access_ctrl
  import mem_ctrl_defs::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              addr_err,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [31:0]       ram_dina,
  input  logic [31:0]       ram_douta
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] word_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              sign_ext_q;
  logic [15:0]       wdata_q;
  logic              addr_err_q;
  logic              req_bad;
  logic [31:0]       ld_data;
  logic [31:0]       st_word;
  logic              unused_addr_hi;

  // Upper address bits alias away.
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign req_bad  = misaligned(size, addr[1:0]);
  assign ready    = (state == S_DONE);
  assign addr_err = ready & addr_err_q;

  mem_lane_align u_align (
    .ld_word  (ram_douta),
    .st_old   (ram_douta),
    .wdata    ({16'h0000, wdata_q}),
    .offset   (off_q),
    .size     (size_q),
    .sign_ext (sign_ext_q),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  // State register, request capture and load result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rdata      <= 32'h0;
      addr_err_q <= 1'b0;
      word_q     <= '0;
      off_q      <= 2'b00;
      size_q     <= SZ_BYTE;
      sign_ext_q <= 1'b0;
      wdata_q    <= 16'h0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && req) begin
        word_q     <= addr[ADDR_W+1:2];
        off_q      <= addr[1:0];
        size_q     <= size;
        sign_ext_q <= sign_ext;
        wdata_q    <= wdata[15:0];
        addr_err_q <= req_bad;
      end
      if (state == S_RD_WAIT) rdata <= ld_data;
    end
  end

  // Next state and RAM port drive; reset always blocks a write.
  always_comb begin
    state_nx  = state;
    ram_wea   = 1'b0;
    ram_addra = word_q;
    ram_dina  = wdata;
    case (state)
      S_IDLE: begin
        ram_addra = addr[ADDR_W+1:2];
        if (req) begin
          if (req_bad) begin
            state_nx = S_DONE;
          end else if (!we) begin
            state_nx = S_RD_WAIT;
          end else if (size[1]) begin
            ram_wea  = 1'b1;
            state_nx = S_DONE;
          end else begin
            state_nx = S_RMW_WAIT;
          end
        end
      end
      S_RD_WAIT: state_nx = S_DONE;
      S_RMW_WAIT: begin
        ram_wea  = 1'b1;
        ram_dina = st_word;
        state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (rst) ram_wea = 1'b0;
  end

endmodule
